brick_matrix_writer: RTL and testbench

- Owns and updates the brick occupancy matrix that the collision logic reads.
- Loads a level's initial brick layout, then clears the brick cell struck by a missile whenever a missile–brick hit is reported.
- Drives the live matrix and a remaining-brick count to the collision and drawing logic, and a per-brick destroy pulse to scoring.

---
 rtl/brick_matrix_writer.sv | 167 ++++++++++++++++
 tb/tb_brick_matrix_writer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_matrix_writer.sv
// brick_matrix_writer
// Holds the live brick occupancy matrix. It loads a level layout on request.
// When a missile-brick hit is reported, it clears the single brick cell that
// lies under the missile centre. It drives the matrix, the remaining-brick
// count and a one-cycle destroy pulse to the rest of the game.
module brick_matrix_writer #(
    parameter int BRICK_WIDTH   = 32,
    parameter int BRICK_HEIGHT  = 32,
    parameter int MISSLE_WIDTH  = 10,
    parameter int MISSLE_HEIGHT = 10,
    parameter int ROWS          = 10,
    parameter int COLS          = 10
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         loadLevel,
    input  logic [0:ROWS-1][COLS-1:0]    initMatrix,
    input  logic                         hitRequest,
    input  logic [10:0]                  missleTopLeftX,
    input  logic [10:0]                  missleTopLeftY,
    input  logic [10:0]                  matrixTopLeftX,
    input  logic [10:0]                  matrixTopLeftY,
    output logic [0:ROWS-1][COLS-1:0]    brickMatrix,
    output logic [6:0]                   bricksRemaining,
    output logic                         brickDestroyed,
    output logic                         busy
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        CLEAR,
        WAIT_RELEASE
    } state_t;

    state_t state, nextState;

    logic              hitPrev;
    logic              hitRise;
    logic signed [11:0] offX, offY;
    logic [10:0]       colCalc, rowCalc;
    logic              hitValid;
    logic [ROW_W-1:0]  rowLatch;
    logic [COL_W-1:0]  colLatch;
    logic              captureEn;
    logic              clearNow;
    logic [6:0]        loadCount;

    assign hitRise = hitRequest & ~hitPrev;
    assign busy    = (state != IDLE);

    // Map the latched missile-centre offset onto a cell and check that it falls inside the matrix
    always_comb begin
        colCalc  = 11'(offX[10:0] / 11'(BRICK_WIDTH));
        rowCalc  = 11'(offY[10:0] / 11'(BRICK_HEIGHT));
        hitValid = !offX[11] && !offY[11] &&
                   (colCalc < 11'(COLS)) && (rowCalc < 11'(ROWS));
    end

    // Count the bricks in the incoming layout so the count is correct the moment a level loads
    always_comb begin
        loadCount = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                loadCount = loadCount + 7'(initMatrix[r][c]);
            end
        end
    end

    // Next-state logic; a level load overrides everything and aborts any hit in progress
    always_comb begin
        nextState = state;
        captureEn = 1'b0;
        clearNow  = 1'b0;
        case (state)
            IDLE: begin
                if (hitRise) begin
                    captureEn = 1'b1;
                    nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                nextState = hitValid ? CLEAR : WAIT_RELEASE;
            end
            CLEAR: begin
                clearNow  = brickMatrix[rowLatch][colLatch];
                nextState = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!hitRequest) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (loadLevel) begin
            nextState = IDLE;
            captureEn = 1'b0;
            clearNow  = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Remember last hit level every cycle so a held hit never retriggers, even across a load
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hitPrev <= 1'b0;
        end else begin
            hitPrev <= hitRequest;
        end
    end

    // Latch the signed missile-centre offsets relative to the matrix origin when a hit starts
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            offX <= '0;
            offY <= '0;
        end else if (captureEn) begin
            offX <= $signed({1'b0, missleTopLeftX} + 12'(MISSLE_WIDTH / 2) - {1'b0, matrixTopLeftX});
            offY <= $signed({1'b0, missleTopLeftY} + 12'(MISSLE_HEIGHT / 2) - {1'b0, matrixTopLeftY});
        end
    end

    // Hold the target cell coordinates once the hit is known to land inside the matrix
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rowLatch <= '0;
            colLatch <= '0;
        end else if (state == CAPTURE && hitValid) begin
            rowLatch <= rowCalc[ROW_W-1:0];
            colLatch <= colCalc[COL_W-1:0];
        end
    end

    // Matrix, count and destroy pulse; clears only a set bit so the count can never underflow
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            brickMatrix     <= '0;
            bricksRemaining <= '0;
            brickDestroyed  <= 1'b0;
        end else if (loadLevel) begin
            brickMatrix     <= initMatrix;
            bricksRemaining <= loadCount;
            brickDestroyed  <= 1'b0;
        end else if (clearNow) begin
            brickMatrix[rowLatch][colLatch] <= 1'b0;
            bricksRemaining                 <= bricksRemaining - 7'd1;
            brickDestroyed                  <= 1'b1;
        end else begin
            brickDestroyed  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_brick_matrix_writer.sv
// tb_brick_matrix_writer
// Directed stimulus with literal expectations, plus a cycle-level reference
// model of hit handling that is compared against the DUT on every cycle.
module tb_brick_matrix_writer;

    localparam int BW   = 32;
    localparam int BH   = 32;
    localparam int MW   = 10;
    localparam int MH   = 10;
    localparam int ROWS = 10;
    localparam int COLS = 10;

    logic                      clk;
    logic                      resetN;
    logic                      loadLevel;
    logic [0:ROWS-1][COLS-1:0] initMatrix;
    logic                      hitRequest;
    logic [10:0]               missleTopLeftX;
    logic [10:0]               missleTopLeftY;
    logic [10:0]               matrixTopLeftX;
    logic [10:0]               matrixTopLeftY;
    logic [0:ROWS-1][COLS-1:0] brickMatrix;
    logic [6:0]                bricksRemaining;
    logic                      brickDestroyed;
    logic                      busy;

    int assertCount = 0;
    int failCount   = 0;
    int pulseSeen   = 0;

    // Reference model state
    logic [0:ROWS-1][COLS-1:0] mMatrix = '0;
    int   mCount   = 0;
    logic mPulse   = 1'b0;
    logic mBusy    = 1'b0;
    logic prevHit  = 1'b0;
    logic hitOk    = 1'b0;
    int   hitRow   = 0;
    int   hitCol   = 0;
    int   cyc      = 0;
    int   startCyc = 0;

    logic [0:ROWS-1][COLS-1:0] allOnes;
    logic [0:ROWS-1][COLS-1:0] pattern;

    brick_matrix_writer #(
        .BRICK_WIDTH  (BW),
        .BRICK_HEIGHT (BH),
        .MISSLE_WIDTH (MW),
        .MISSLE_HEIGHT(MH),
        .ROWS         (ROWS),
        .COLS         (COLS)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .loadLevel      (loadLevel),
        .initMatrix     (initMatrix),
        .hitRequest     (hitRequest),
        .missleTopLeftX (missleTopLeftX),
        .missleTopLeftY (missleTopLeftY),
        .matrixTopLeftX (matrixTopLeftX),
        .matrixTopLeftY (matrixTopLeftY),
        .brickMatrix    (brickMatrix),
        .bricksRemaining(bricksRemaining),
        .brickDestroyed (brickDestroyed),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one hit at the given missile position, held for holdCycles, then idle for waitCycles
    task automatic applyStimulus(input logic [10:0] x, input logic [10:0] y,
                                 input int holdCycles, input int waitCycles);
        missleTopLeftX = x;
        missleTopLeftY = y;
        hitRequest     = 1'b1;
        pulseSeen      = 0;
        repeat (holdCycles) begin
            @(negedge clk);
            pulseSeen = pulseSeen + (brickDestroyed ? 1 : 0);
        end
        hitRequest = 1'b0;
        repeat (waitCycles) begin
            @(negedge clk);
            pulseSeen = pulseSeen + (brickDestroyed ? 1 : 0);
        end
    endtask

    task automatic doLoad(input logic [0:ROWS-1][COLS-1:0] m);
        initMatrix = m;
        loadLevel  = 1'b1;
        @(negedge clk);
        loadLevel  = 1'b0;
    endtask

    // Reference model: a hit accepted at edge E0 clears its cell at E0+2 unless a load intervenes;
    // the block then stays busy until hitRequest is seen low (from E0+3 if valid, E0+2 if not)
    initial begin
        int ox, oy, age;
        logic rise;
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) begin
                mMatrix = '0;
                mCount  = 0;
                mPulse  = 1'b0;
                mBusy   = 1'b0;
                prevHit = 1'b0;
            end else begin
                cyc++;
                rise    = hitRequest && !prevHit;
                prevHit = hitRequest;
                mPulse  = 1'b0;
                if (loadLevel) begin
                    mMatrix = initMatrix;
                    mCount  = $countones(initMatrix);
                    mBusy   = 1'b0;
                end else if (mBusy) begin
                    age = cyc - startCyc;
                    if (hitOk && age == 2 && mMatrix[hitRow][hitCol]) begin
                        mMatrix[hitRow][hitCol] = 1'b0;
                        mCount--;
                        mPulse = 1'b1;
                    end
                    if (!hitRequest && age >= (hitOk ? 3 : 2)) begin
                        mBusy = 1'b0;
                    end
                end else if (rise) begin
                    mBusy    = 1'b1;
                    startCyc = cyc;
                    ox       = int'(missleTopLeftX) + MW / 2 - int'(matrixTopLeftX);
                    oy       = int'(missleTopLeftY) + MH / 2 - int'(matrixTopLeftY);
                    hitOk    = (ox >= 0) && (oy >= 0) && (ox / BW < COLS) && (oy / BH < ROWS);
                    hitCol   = hitOk ? ox / BW : 0;
                    hitRow   = hitOk ? oy / BH : 0;
                end
            end
        end
    end

    // Compare every DUT output against the model once per cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model matrix", 128'(brickMatrix), 128'(mMatrix));
            checkOutput("model count", 128'(bricksRemaining), 128'(mCount));
            checkOutput("model pulse", 128'(brickDestroyed), 128'(mPulse));
            checkOutput("model busy", 128'(busy), 128'(mBusy));
        end
    end

    initial begin
        resetN         = 1'b0;
        loadLevel      = 1'b0;
        initMatrix     = '0;
        hitRequest     = 1'b0;
        missleTopLeftX = '0;
        missleTopLeftY = '0;
        matrixTopLeftX = 11'd64;
        matrixTopLeftY = 11'd32;
        allOnes        = '1;
        for (int r = 0; r < ROWS; r++) pattern[r] = 10'b1010101010;

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        checkOutput("reset matrix", 128'(brickMatrix), 128'd0);
        checkOutput("reset count", 128'(bricksRemaining), 128'd0);
        checkOutput("reset busy", 128'(busy), 128'd0);
        resetN = 1'b1;
        @(negedge clk);

        $display("[TB] load all ones");
        doLoad(allOnes);
        checkOutput("load matrix", 128'(brickMatrix), 128'(allOnes));
        checkOutput("load count", 128'(bricksRemaining), 128'd100);
        checkOutput("load busy", 128'(busy), 128'd0);

        $display("[TB] basic hit");
        missleTopLeftX = 11'd100;
        missleTopLeftY = 11'd40;
        hitRequest     = 1'b1;
        @(negedge clk);
        hitRequest = 1'b0;
        checkOutput("hit busy E0", 128'(busy), 128'd1);
        @(negedge clk);
        checkOutput("hit no pulse E1", 128'(brickDestroyed), 128'd0);
        @(negedge clk);
        checkOutput("hit pulse E2", 128'(brickDestroyed), 128'd1);
        checkOutput("hit cell 0,1", 128'(brickMatrix[0][1]), 128'd0);
        checkOutput("hit count", 128'(bricksRemaining), 128'd99);
        @(negedge clk);
        checkOutput("hit pulse E3", 128'(brickDestroyed), 128'd0);
        checkOutput("hit idle", 128'(busy), 128'd0);

        $display("[TB] held hit");
        doLoad(allOnes);
        applyStimulus(11'd100, 11'd40, 10, 0);
        checkOutput("held pulses", 128'(pulseSeen), 128'd1);
        checkOutput("held busy", 128'(busy), 128'd1);
        @(negedge clk);
        checkOutput("held release", 128'(busy), 128'd0);
        checkOutput("held count", 128'(bricksRemaining), 128'd99);

        $display("[TB] out of range");
        applyStimulus(11'd40, 11'd40, 1, 4);
        checkOutput("left pulses", 128'(pulseSeen), 128'd0);
        checkOutput("left count", 128'(bricksRemaining), 128'd99);
        applyStimulus(11'd400, 11'd380, 1, 4);
        checkOutput("bottom pulses", 128'(pulseSeen), 128'd0);
        checkOutput("bottom count", 128'(bricksRemaining), 128'd99);

        $display("[TB] empty cell");
        applyStimulus(11'd100, 11'd40, 1, 4);
        checkOutput("empty pulses", 128'(pulseSeen), 128'd0);
        checkOutput("empty count", 128'(bricksRemaining), 128'd99);

        $display("[TB] abort in capture");
        initMatrix     = pattern;
        missleTopLeftX = 11'd100;
        missleTopLeftY = 11'd40;
        hitRequest     = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", 128'(busy), 128'd1);
        hitRequest = 1'b0;
        loadLevel  = 1'b1;
        @(negedge clk);
        loadLevel = 1'b0;
        checkOutput("abort matrix", 128'(brickMatrix), 128'(pattern));
        checkOutput("abort count", 128'(bricksRemaining), 128'd50);
        checkOutput("abort idle", 128'(busy), 128'd0);
        applyStimulus(11'd100, 11'd40, 0, 3);
        checkOutput("abort pulses", 128'(pulseSeen), 128'd0);

        $display("[TB] simultaneous load and hit");
        hitRequest = 1'b1;
        loadLevel  = 1'b1;
        @(negedge clk);
        loadLevel = 1'b0;
        applyStimulus(11'd100, 11'd40, 3, 2);
        checkOutput("simul pulses", 128'(pulseSeen), 128'd0);
        checkOutput("simul cell 0,1", 128'(brickMatrix[0][1]), 128'd1);
        checkOutput("simul count", 128'(bricksRemaining), 128'd50);

        $display("[TB] boundary hits");
        applyStimulus(11'd58, 11'd40, 1, 4);
        checkOutput("offX -1 pulses", 128'(pulseSeen), 128'd0);
        applyStimulus(11'd59, 11'd40, 1, 4);
        checkOutput("offX 0 empty pulses", 128'(pulseSeen), 128'd0);
        applyStimulus(11'd378, 11'd40, 1, 4);
        checkOutput("offX 319 pulses", 128'(pulseSeen), 128'd1);
        checkOutput("offX 319 count", 128'(bricksRemaining), 128'd49);
        applyStimulus(11'd379, 11'd40, 1, 4);
        checkOutput("offX 320 pulses", 128'(pulseSeen), 128'd0);
        applyStimulus(11'd352, 11'd320, 1, 4);
        checkOutput("cell 9,9 pulses", 128'(pulseSeen), 128'd1);
        checkOutput("cell 9,9 bit", 128'(brickMatrix[9][9]), 128'd0);
        applyStimulus(11'd100, 11'd347, 1, 4);
        checkOutput("offY 320 pulses", 128'(pulseSeen), 128'd0);
        applyStimulus(11'd100, 11'd346, 1, 4);
        checkOutput("offY 319 pulses", 128'(pulseSeen), 128'd1);
        checkOutput("offY 319 count", 128'(bricksRemaining), 128'd47);

        $display("[TB] async reset in wait release");
        missleTopLeftX = 11'd164;
        missleTopLeftY = 11'd40;
        hitRequest     = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("pre-reset busy", 128'(busy), 128'd1);
        checkOutput("pre-reset count", 128'(bricksRemaining), 128'd46);
        resetN = 1'b0;
        #1;
        checkOutput("async matrix", 128'(brickMatrix), 128'd0);
        checkOutput("async count", 128'(bricksRemaining), 128'd0);
        checkOutput("async pulse", 128'(brickDestroyed), 128'd0);
        checkOutput("async busy", 128'(busy), 128'd0);
        hitRequest = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
